wb_queue: RTL and testbench

Write-back queue sitting directly upstream of the register file write port. It accepts (destination, data, PC) result triples from the execute stage, buffers up to DEPTH of them in order, and drains one per cycle into the register file's `wr_en`/`wr_addr`/`dat_in` inputs. It also provides youngest-match forwarding of still-pending writes to the two register read ports. Repeated results carrying the PC of the last accepted result are dropped.

---
 rtl/wb_queue.sv | 123 ++++++++++++
 tb/tb_wb_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue feeding the register file write port: in-order buffering,
// duplicate-PC drop and youngest-match forwarding to two read ports.
module wb_queue #(
  parameter int pw    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [pw:0]                push_addr,
  input  logic [7:0]                 push_data,
  input  logic [11:0]                push_pc,
  input  logic                       hold,
  output logic                       wr_en,
  output logic [pw:0]                wr_addr,
  output logic [7:0]                 dat_out,
  input  logic [pw:0]                rd_addrA,
  input  logic [pw:0]                rd_addrB,
  output logic                       fwdA_hit,
  output logic                       fwdB_hit,
  output logic [7:0]                 fwdA_dat,
  output logic [7:0]                 fwdB_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [pw:0]   r_addr [DEPTH];
  logic [7:0]    r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [11:0]   r_last_pc;
  logic          r_last_pc_vld;

  logic          w_push;
  logic          w_dup;
  logic          w_enq;
  logic          w_pop;
  logic [AW-1:0] w_idx;
  logic          w_hitA;
  logic          w_hitB;
  logic [7:0]    w_datA;
  logic [7:0]    w_datB;

  assign empty      = (r_count == '0);
  assign full       = (r_count == CW'(DEPTH));
  assign count      = r_count;
  assign push_ready = !full && reset_n;
  assign w_push     = push_valid && push_ready;
  assign w_dup      = r_last_pc_vld && (push_pc == r_last_pc);
  assign w_enq      = w_push && !w_dup;
  assign w_pop      = !empty && !hold && reset_n;

  assign wr_en   = w_pop;
  assign wr_addr = r_addr[r_head];
  assign dat_out = r_data[r_head];

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    w_idx  = r_head;
    w_hitA = 1'b0;
    w_hitB = 1'b0;
    w_datA = '0;
    w_datB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if (CW'(i) < r_count) begin
        if (r_addr[w_idx] == rd_addrA) begin
          w_hitA = 1'b1;
          w_datA = r_data[w_idx];
        end
        if (r_addr[w_idx] == rd_addrB) begin
          w_hitB = 1'b1;
          w_datB = r_data[w_idx];
        end
      end
    end
    if (!reset_n) begin
      w_hitA = 1'b0;
      w_hitB = 1'b0;
      w_datA = '0;
      w_datB = '0;
    end
  end

  assign fwdA_hit = w_hitA;
  assign fwdB_hit = w_hitB;
  assign fwdA_dat = w_datA;
  assign fwdB_dat = w_datB;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_last_pc_vld <= 1'b0;
    end else begin
      if (w_enq) begin
        r_tail        <= r_tail + 1'b1;
        r_last_pc_vld <= 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
    end
  end

  // Entry storage and last PC carry no reset; validity comes from the control state.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= push_addr;
      r_data[r_tail] <= push_data;
      r_last_pc      <= push_pc;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model used as scoreboard, a negedge
// monitor comparing every DUT output, directed scenarios and random traffic.
module tb_wb_queue;

  localparam int PW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          push_valid;
  logic          push_ready;
  logic [PW:0]   push_addr;
  logic [7:0]    push_data;
  logic [11:0]   push_pc;
  logic          hold;
  logic          wr_en;
  logic [PW:0]   wr_addr;
  logic [7:0]    dat_out;
  logic [PW:0]   rd_addrA;
  logic [PW:0]   rd_addrB;
  logic          fwdA_hit;
  logic          fwdB_hit;
  logic [7:0]    fwdA_dat;
  logic [7:0]    fwdB_dat;
  logic [$clog2(DEPTH):0] count;
  logic          empty;
  logic          full;

  wb_queue #(.pw(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data), .push_pc(push_pc),
    .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .dat_out(dat_out),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit),
    .fwdA_dat(fwdA_dat), .fwdB_dat(fwdB_dat),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        mq[$];
  logic [11:0] m_last_pc;
  bit          m_last_vld = 0;
  bit          popped = 0;
  bit          mon_en = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted pushes enter the expected-write queue.
  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_last_vld = 0;
    end else if (push_valid && (mq.size() + (popped ? 1 : 0)) < DEPTH) begin
      if (!(m_last_vld && push_pc == m_last_pc)) begin
        mq.push_back('{a: push_addr, d: push_data});
        m_last_pc  = push_pc;
        m_last_vld = 1;
      end
    end
    popped = 0;
  end

  // Monitor: compares outputs against the model and retires expected writes.
  always @(negedge clk) begin
    int   sz;
    bit   ew;
    bit   ehA, ehB;
    logic [7:0] edA, edB;
    if (mon_en) begin
      sz  = mq.size();
      ew  = reset_n && !hold && sz > 0;
      ehA = 0; ehB = 0; edA = '0; edB = '0;
      if (reset_n) begin
        for (int i = 0; i < sz; i++) begin
          if (mq[i].a == rd_addrA) begin ehA = 1; edA = mq[i].d; end
          if (mq[i].a == rd_addrB) begin ehB = 1; edB = mq[i].d; end
        end
      end
      chk("push_ready", 32'(push_ready), 32'(reset_n && sz < DEPTH));
      chk("wr_en", 32'(wr_en), 32'(ew));
      chk("count", 32'(count), 32'(sz));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("fwdA_hit", 32'(fwdA_hit), 32'(ehA));
      chk("fwdB_hit", 32'(fwdB_hit), 32'(ehB));
      if (reset_n) begin
        chk("fwdA_dat", 32'(fwdA_dat), 32'(edA));
        chk("fwdB_dat", 32'(fwdB_dat), 32'(edB));
      end
      if (ew) begin
        chk("wr_addr", 32'(wr_addr), 32'(mq[0].a));
        chk("dat_out", 32'(dat_out), 32'(mq[0].d));
        void'(mq.pop_front());
        popped = 1;
      end
      if (wr_en) wr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    push_valid = 1'b0;
    hold       = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic set_push(input logic [PW:0] a, input logic [7:0] d, input logic [11:0] pc);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    push_pc    = pc;
  endtask

  initial begin
    int maxc;
    reset_n = 1'b0; push_valid = 1'b0; hold = 1'b0;
    push_addr = '0; push_data = '0; push_pc = '0;
    rd_addrA = '0; rd_addrB = '0;
    step();
    mon_en = 1;
    reset_n = 1'b1;
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(push_ready), 32'd1);

    // Single push, one-cycle latency to wr_en
    set_push(5'd3, 8'hA5, 12'd1);
    step();
    push_valid = 1'b0;
    #2;
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_wr_en", 32'(wr_en), 32'd1);
    chk("t1_wr_addr", 32'(wr_addr), 32'd3);
    chk("t1_dat_out", 32'(dat_out), 32'hA5);
    step();
    #2;
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill under hold, stall a fifth push, then drain exactly four
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_push(5'(i + 1), 8'(10 + i), 12'(i + 1));
      step();
    end
    set_push(5'd9, 8'd99, 12'd5);
    #2;
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ready", 32'(push_ready), 32'd0);
    step();
    step();
    #2;
    chk("t2_stall_count", 32'(count), 32'd4);
    push_valid = 1'b0;
    hold = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t2_drain_cnt", 32'(wr_cnt), 32'd4);

    // Forwarding: youngest match wins, miss reads zero
    do_reset();
    hold = 1'b1;
    set_push(5'd2, 8'h11, 12'd5); step();
    set_push(5'd2, 8'h22, 12'd6); step();
    set_push(5'd7, 8'h33, 12'd7); step();
    push_valid = 1'b0;
    rd_addrA = 5'd2;
    rd_addrB = 5'd7;
    #2;
    chk("t3_fwdA_hit", 32'(fwdA_hit), 32'd1);
    chk("t3_fwdA_dat", 32'(fwdA_dat), 32'h22);
    chk("t3_fwdB_hit", 32'(fwdB_hit), 32'd1);
    chk("t3_fwdB_dat", 32'(fwdB_dat), 32'h33);
    rd_addrA = 5'd4;
    #1;
    chk("t3_missA_hit", 32'(fwdA_hit), 32'd0);
    chk("t3_missA_dat", 32'(fwdA_dat), 32'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Duplicate PC drop
    do_reset();
    hold = 1'b1;
    set_push(5'd1, 8'h01, 12'd9); step();
    set_push(5'd1, 8'h02, 12'd9); step();
    push_valid = 1'b0;
    #2;
    chk("t4_dup_count", 32'(count), 32'd1);
    set_push(5'd1, 8'h03, 12'd10); step();
    push_valid = 1'b0;
    #2;
    chk("t4_new_count", 32'(count), 32'd2);
    hold = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Streaming across pointer wrap
    do_reset();
    maxc = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_push(5'(i), 8'(8'h40 + i), 12'(100 + i));
      step();
      #2;
      if (int'(count) > maxc) maxc = int'(count);
    end
    push_valid = 1'b0;
    step(); step();
    chk("t5_max_count", 32'(maxc), 32'd1);

    // Mid-operation reset discards entries and clears last PC
    do_reset();
    hold = 1'b1;
    set_push(5'd4, 8'h50, 12'd20); step();
    set_push(5'd5, 8'h51, 12'd21); step();
    set_push(5'd6, 8'h52, 12'd22); step();
    push_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    hold = 1'b0;
    #2;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    hold = 1'b1;
    set_push(5'd5, 8'h77, 12'd22); step();
    push_valid = 1'b0;
    #2;
    chk("t6_post_count", 32'(count), 32'd1);
    hold = 1'b0;
    step(); step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      reset_n    = ($urandom % 60) != 0;
      push_valid = ($urandom % 4) != 0;
      push_addr  = 5'($urandom_range(0, 7));
      push_data  = 8'($urandom);
      push_pc    = 12'($urandom_range(0, 5));
      hold       = ($urandom % 4) == 0;
      rd_addrA   = 5'($urandom_range(0, 7));
      rd_addrB   = 5'($urandom_range(0, 7));
      step();
    end
    reset_n = 1'b1;
    push_valid = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) step();
    #2;
    chk("final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
